// File: rtl/pc_mt_sched.sv
// Multithreaded fetch-PC scheduler: one PC per hardware thread, round-robin selection
// over enabled threads that are not waiting on a branch, one registered fetch per cycle.
module pc_mt_sched #(
    parameter int              XLEN     = 32,
    parameter int              NTHREADS = 8,
    parameter int              TID_W    = $clog2(NTHREADS),
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic [NTHREADS-1:0] thread_en_i,
    input  logic                br_issue_i,
    input  logic [TID_W-1:0]    br_issue_tid_i,
    input  logic                br_res_valid_i,
    input  logic [TID_W-1:0]    br_res_tid_i,
    input  logic                br_res_taken_i,
    input  logic [XLEN-1:0]     br_res_pc_i,
    output logic                br_res_ack_o,
    output logic [XLEN-1:0]     pc_o,
    output logic [TID_W-1:0]    tid_o,
    output logic                valid_o,
    output logic [NTHREADS-1:0] blocked_o
);

    logic [XLEN-1:0]     pcTbl_q [NTHREADS];
    logic [XLEN-1:0]     pcTbl_d [NTHREADS];
    logic [NTHREADS-1:0] blocked_q;
    logic [NTHREADS-1:0] blocked_d;
    logic [TID_W-1:0]    rrPtr_q;
    logic [XLEN-1:0]     pcOut_q;
    logic [TID_W-1:0]    tidOut_q;
    logic                validOut_q;

    logic [NTHREADS-1:0] elig;
    logic [TID_W-1:0]    selTid;
    logic [TID_W-1:0]    probeTid;
    logic                selFound;
    logic                advance;
    logic                resAccept;

    assign elig         = thread_en_i & ~blocked_q;
    assign resAccept    = br_res_valid_i & blocked_q[br_res_tid_i];
    assign advance      = ~stall_i & selFound;
    assign br_res_ack_o = resAccept;
    assign pc_o         = pcOut_q;
    assign tid_o        = tidOut_q;
    assign valid_o      = validOut_q;
    assign blocked_o    = blocked_q;

    // Offset NTHREADS truncates to rrPtr itself, so the last-served thread is tried last.
    always_comb begin
        selTid   = '0;
        probeTid = '0;
        selFound = 1'b0;
        for (int k = 1; k <= NTHREADS; k++) begin
            probeTid = rrPtr_q + TID_W'(k);
            if (!selFound && elig[probeTid]) begin
                selTid   = probeTid;
                selFound = 1'b1;
            end
        end
    end

    // Resolution clears before issue sets, so a same-thread pair leaves the thread blocked.
    always_comb begin
        blocked_d = blocked_q;
        pcTbl_d   = pcTbl_q;
        if (resAccept) begin
            blocked_d[br_res_tid_i] = 1'b0;
            if (br_res_taken_i) begin
                pcTbl_d[br_res_tid_i] = br_res_pc_i;
            end
        end
        if (br_issue_i) begin
            blocked_d[br_issue_tid_i] = 1'b1;
        end
        if (advance) begin
            pcTbl_d[selTid] = pcTbl_q[selTid] + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NTHREADS; i++) begin
                pcTbl_q[i] <= RESET_PC;
            end
            blocked_q  <= '0;
            rrPtr_q    <= TID_W'(NTHREADS - 1);
            pcOut_q    <= RESET_PC;
            tidOut_q   <= '0;
            validOut_q <= 1'b0;
        end else begin
            pcTbl_q   <= pcTbl_d;
            blocked_q <= blocked_d;
            if (!stall_i) begin
                validOut_q <= selFound;
                if (selFound) begin
                    pcOut_q  <= pcTbl_q[selTid];
                    tidOut_q <= selTid;
                    rrPtr_q  <= selTid;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_mt_sched.sv
// Directed bench for pc_mt_sched: expected fetches are queued by the stimulus and
// popped by an independent monitor whenever a fresh fetch appears on the outputs.
module tb_pc_mt_sched;

    typedef struct packed {
        logic [2:0]  tid;
        logic [31:0] pc;
    } fetch_t;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic [7:0]  thread_en_i;
    logic        br_issue_i;
    logic [2:0]  br_issue_tid_i;
    logic        br_res_valid_i;
    logic [2:0]  br_res_tid_i;
    logic        br_res_taken_i;
    logic [31:0] br_res_pc_i;
    logic        br_res_ack_o;
    logic [31:0] pc_o;
    logic [2:0]  tid_o;
    logic        valid_o;
    logic [7:0]  blocked_o;

    fetch_t sb[$];
    int     vectors     = 0;
    int     miscompares = 0;
    logic   freshEdge   = 1'b0;

    pc_mt_sched dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .thread_en_i    (thread_en_i),
        .br_issue_i     (br_issue_i),
        .br_issue_tid_i (br_issue_tid_i),
        .br_res_valid_i (br_res_valid_i),
        .br_res_tid_i   (br_res_tid_i),
        .br_res_taken_i (br_res_taken_i),
        .br_res_pc_i    (br_res_pc_i),
        .br_res_ack_o   (br_res_ack_o),
        .pc_o           (pc_o),
        .tid_o          (tid_o),
        .valid_o        (valid_o),
        .blocked_o      (blocked_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectFetch(input logic [2:0] tid, input logic [31:0] pc);
        sb.push_back('{tid: tid, pc: pc});
    endtask

    // Inputs change just after a rising edge; branch strobes last exactly one cycle.
    task automatic applyStimulus(input logic [7:0] en, input logic stall);
        thread_en_i = en;
        stall_i     = stall;
        #1;
        @(posedge clk);
        #1;
        br_issue_i     = 1'b0;
        br_res_valid_i = 1'b0;
    endtask

    task automatic setResolve(input logic [2:0] tid, input logic taken, input logic [31:0] pc);
        br_res_valid_i = 1'b1;
        br_res_tid_i   = tid;
        br_res_taken_i = taken;
        br_res_pc_i    = pc;
        #1;
    endtask

    task automatic setIssue(input logic [2:0] tid);
        br_issue_i     = 1'b1;
        br_issue_tid_i = tid;
    endtask

    // A fetch is new only if the edge that produced it was out of reset and unstalled.
    always @(posedge clk) freshEdge <= rst && !stall_i;

    always @(negedge clk) begin
        if (valid_o && freshEdge) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpectedFetch: got tid %0d pc 0x%0h, expected none", tid_o, pc_o);
            end else begin
                fetch_t e;
                e = sb.pop_front();
                checkOutput("fetchTid", 32'(tid_o), 32'(e.tid));
                checkOutput("fetchPc", pc_o, e.pc);
            end
        end
    end

    initial begin
        logic [2:0]  seqTid [8];
        logic [31:0] seqPc  [8];
        rst            = 1'b0;
        stall_i        = 1'b0;
        thread_en_i    = 8'hFF;
        br_issue_i     = 1'b0;
        br_issue_tid_i = '0;
        br_res_valid_i = 1'b0;
        br_res_tid_i   = '0;
        br_res_taken_i = 1'b0;
        br_res_pc_i    = '0;

        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("resetPc", pc_o, 32'h0);
        checkOutput("resetTid", 32'(tid_o), 32'h0);
        checkOutput("resetValid", 32'(valid_o), 32'h0);
        checkOutput("resetBlocked", 32'(blocked_o), 32'h0);
        rst = 1'b1;

        for (int k = 0; k < 8; k++) expectFetch(3'(k), 32'h0);
        expectFetch(3'd0, 32'h4);
        repeat (9) applyStimulus(8'hFF, 1'b0);

        expectFetch(3'd2, 32'h4);
        expectFetch(3'd5, 32'h4);
        expectFetch(3'd7, 32'h4);
        expectFetch(3'd0, 32'h8);
        expectFetch(3'd2, 32'h8);
        repeat (5) applyStimulus(8'hA5, 1'b0);

        setIssue(3'd3);
        expectFetch(3'd3, 32'h4);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("blockedAfterIssue", 32'(blocked_o), 32'h08);

        seqTid = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd4};
        seqPc  = '{32'h4, 32'h8, 32'h4, 32'h8, 32'hC, 32'h4, 32'hC, 32'h8};
        for (int k = 0; k < 8; k++) expectFetch(seqTid[k], seqPc[k]);
        repeat (8) applyStimulus(8'hFF, 1'b0);
        checkOutput("blockedHeld", 32'(blocked_o), 32'h08);

        setResolve(3'd3, 1'b1, 32'h1000);
        checkOutput("ackTaken", 32'(br_res_ack_o), 32'h1);
        expectFetch(3'd5, 32'hC);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("blockedAfterRes", 32'(blocked_o), 32'h0);
        expectFetch(3'd3, 32'h1000);
        expectFetch(3'd3, 32'h1004);
        repeat (2) applyStimulus(8'h08, 1'b0);

        setIssue(3'd3);
        expectFetch(3'd3, 32'h1008);
        applyStimulus(8'h08, 1'b0);
        checkOutput("blockedReissue", 32'(blocked_o), 32'h08);
        setResolve(3'd3, 1'b0, 32'hBAD0);
        checkOutput("ackNotTaken", 32'(br_res_ack_o), 32'h1);
        applyStimulus(8'h08, 1'b0);
        checkOutput("idleValid", 32'(valid_o), 32'h0);
        checkOutput("idlePcHold", pc_o, 32'h1008);
        checkOutput("idleTidHold", 32'(tid_o), 32'h3);
        checkOutput("blockedNotTaken", 32'(blocked_o), 32'h0);
        setResolve(3'd5, 1'b1, 32'hDEAD0);
        checkOutput("ackUnblocked", 32'(br_res_ack_o), 32'h0);
        expectFetch(3'd3, 32'h100C);
        applyStimulus(8'h08, 1'b0);
        expectFetch(3'd5, 32'h10);
        applyStimulus(8'h20, 1'b0);

        setIssue(3'd6);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("stallBlocked", 32'(blocked_o), 32'h40);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(8'hFF, 1'b1);
            checkOutput("stallPc", pc_o, 32'h10);
            checkOutput("stallTid", 32'(tid_o), 32'h5);
            checkOutput("stallValid", 32'(valid_o), 32'h1);
        end
        expectFetch(3'd7, 32'hC);
        applyStimulus(8'hFF, 1'b0);
        setResolve(3'd6, 1'b0, 32'h0);
        checkOutput("ackAfterStall", 32'(br_res_ack_o), 32'h1);
        expectFetch(3'd0, 32'h10);
        applyStimulus(8'hFF, 1'b0);
        expectFetch(3'd6, 32'h8);
        applyStimulus(8'h40, 1'b0);
        checkOutput("blockedCleared", 32'(blocked_o), 32'h0);

        applyStimulus(8'h00, 1'b0);
        checkOutput("disabledValid", 32'(valid_o), 32'h0);

        rst = 1'b0;
        setIssue(3'd2);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("midResetPc", pc_o, 32'h0);
        checkOutput("midResetTid", 32'(tid_o), 32'h0);
        checkOutput("midResetValid", 32'(valid_o), 32'h0);
        checkOutput("midResetBlocked", 32'(blocked_o), 32'h0);
        rst = 1'b1;
        expectFetch(3'd0, 32'h0);
        expectFetch(3'd1, 32'h0);
        repeat (2) applyStimulus(8'hFF, 1'b0);

        @(negedge clk);
        #1;
        checkOutput("scoreboardDrained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
